// File: rtl/multicycle_divider_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states and counter sizing.
`timescale 1ns/1ps
package multicycle_divider_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = $clog2(XLEN_DEFAULT);

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; only built when DIV_EARLY_OUT_EN is defined.
`ifdef DIV_EARLY_OUT_EN
`timescale 1ns/1ps
module leading_zero_count #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]       value_i,
    output logic [$clog2(XLEN):0] count_o
);

    localparam int unsigned LZ_W = $clog2(XLEN) + 1;

    logic found;

    // Scan from the MSB; the first set bit fixes the count, all-zero yields XLEN.
    always_comb begin
        count_o = LZ_W'(XLEN);
        found   = 1'b0;
        for (int i = int'(XLEN) - 1; i >= 0; i--) begin
            if (!found && value_i[i]) begin
                count_o = LZ_W'(int'(XLEN) - 1 - i);
                found   = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/multicycle_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with start/busy/done/ack handshake and flush.
// Build option DIV_EARLY_OUT_EN skips the leading zero quotient bits of small dividends.
`timescale 1ns/1ps
module multicycle_divider
    import multicycle_divider_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CNT_W   = cnt_width(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              signed_op_c, a_neg_c, b_neg_c, ovf_c, accept_c, ge_c;
    logic [XLEN-1:0]   a_abs_c, b_abs_c;
    logic [XLEN:0]     r_prime_c;
    logic [CNT_W-1:0]  cnt_init_c;

    assign signed_op_c = ~op_i[0];
    assign a_neg_c     = signed_op_c & dividend_i[XLEN-1];
    assign b_neg_c     = signed_op_c & divisor_i[XLEN-1];
    assign a_abs_c     = a_neg_c ? -dividend_i : dividend_i;
    assign b_abs_c     = b_neg_c ? -divisor_i  : divisor_i;
    assign ovf_c       = signed_op_c && (dividend_i == INT_MIN) && (divisor_i == '1);
    assign accept_c    = start_i && !flush_i &&
                         ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ack_i));

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign r_prime_c   = {r_q, a_q[cnt_q]};
    assign ge_c        = r_prime_c >= {1'b0, b_q};

`ifdef DIV_EARLY_OUT_EN
    localparam int unsigned LZ_W = CNT_W + 1;
    logic [LZ_W-1:0] lz_c;

    leading_zero_count #(.XLEN(XLEN)) u_lzc (
        .value_i (a_abs_c),
        .count_o (lz_c)
    );

    assign cnt_init_c = CNT_W'(LZ_W'(XLEN - 1) - lz_c);
`else
    assign cnt_init_c = CNT_W'(XLEN - 1);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        q_d       = q_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            ST_CALC: begin
                q_d = {q_q[XLEN-2:0], ge_c};
                r_d = ge_c ? XLEN'(r_prime_c - {1'b0, b_q}) : r_prime_c[XLEN-1:0];
                if (cnt_q == '0) begin
                    state_d = ST_FIXUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIXUP: begin
                result_d = is_rem_q ? (neg_rem_q ? -r_q : r_q)
                                    : (neg_quo_q ? -q_q : q_q);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (ack_i) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // Launch a new operation; special cases resolve straight to DONE.
        if (accept_c) begin
            a_d       = a_abs_c;
            b_d       = b_abs_c;
            r_d       = '0;
            q_d       = '0;
            cnt_d     = cnt_init_c;
            is_rem_d  = op_i[1];
            neg_quo_d = (op_i == OP_DIV) && (a_neg_c != b_neg_c);
            neg_rem_d = (op_i == OP_REM) && a_neg_c;
            if (divisor_i == '0) begin
                result_d = op_i[1] ? dividend_i : '1;
                state_d  = ST_DONE;
            end else if (ovf_c) begin
                result_d = op_i[1] ? '0 : INT_MIN;
                state_d  = ST_DONE;
`ifdef DIV_EARLY_OUT_EN
            end else if (a_abs_c == '0) begin
                result_d = '0;
                state_d  = ST_DONE;
`endif
            end else begin
                state_d  = ST_CALC;
            end
        end

        if (flush_i) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIXUP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            q_q       <= q_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider: directed RV32M cases plus a random sweep
// against an arithmetic reference model; latency expectations follow DIV_EARLY_OUT_EN.
`timescale 1ns/1ps
module tb_multicycle_divider;
    import multicycle_divider_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i, start_i, flush_i, ack_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i, divisor_i, result_o;
    logic            busy_o, done_o;

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [31:0]     last_exp = '0;

    always #5 clk_i = ~clk_i;

    multicycle_divider #(.XLEN(XLEN)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .ack_i      (ack_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    // Reference result from plain 64-bit arithmetic (truncating division, RISC-V zero rules).
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Expected cycles from the start-sampling edge (inclusive) until done_o is seen high.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] abs_a;
        int          msb;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        abs_a = (!op[0] && a[31]) ? -a : a;
`ifdef DIV_EARLY_OUT_EN
        if (abs_a == 32'd0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (abs_a[i]) msb = i;
        return msb + 3;
`else
        msb = 0;
        if (abs_a == 32'd0) msb = 0;
        return 34;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation (optionally with ack, for DONE back-to-back) and check it to completion.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_ack, input string tag);
        int          lat   = 0;
        int          nbusy = 0;
        logic [31:0] exp_r;
        int          exp_l;
        exp_r      = ref_res(op, a, b);
        exp_l      = ref_lat(op, a, b);
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        ack_i      = with_ack;
        do begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            ack_i   = 1'b0;
            lat++;
            if (busy_o) nbusy++;
        end while (!done_o && lat < 200);
        check({tag, " done"},        32'(done_o), 32'd1);
        check({tag, " latency"},     32'(lat),    32'(exp_l));
        check({tag, " busy cycles"}, 32'(nbusy),  32'(exp_l - 1));
        check({tag, " result"},      result_o,    exp_r);
        last_exp = exp_r;
    endtask

    task automatic release_done(input string tag);
        ack_i = 1'b1;
        @(posedge clk_i); #1;
        ack_i = 1'b0;
        check({tag, " ack done"}, 32'(done_o), 32'd0);
        check({tag, " ack busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          kind;
        int          seen_done;

        reset_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
        op_i = OP_DIV; dividend_i = '0; divisor_i = '0;
        #12;
        check("reset busy",   32'(busy_o), 32'd0);
        check("reset done",   32'(done_o), 32'd0);
        check("reset result", result_o,    32'd0);
        @(negedge clk_i) reset_i = 1'b0;
        @(posedge clk_i); #1;

        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu 100/7");      release_done("divu 100/7");
        do_op(OP_REMU, 32'd100, 32'd7, 1'b0, "remu 100/7");      release_done("remu 100/7");
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");   release_done("div -7/2");
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem -7/2");   release_done("rem -7/2");
        do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 1'b0, "rem 7/-2");   release_done("rem 7/-2");
        do_op(OP_DIV, 32'd5, 32'd0, 1'b0, "div 5/0");            release_done("div 5/0");
        do_op(OP_REM, 32'd5, 32'd0, 1'b0, "rem 5/0");            release_done("rem 5/0");
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf"); release_done("div ovf");
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem ovf"); release_done("rem ovf");
        do_op(OP_DIVU, 32'd3, 32'd1, 1'b0, "divu 3/1");          release_done("divu 3/1");
        do_op(OP_DIVU, 32'd0, 32'd9, 1'b0, "divu 0/9");          release_done("divu 0/9");

        // Flush ten cycles into CALC: back to IDLE, result held, done never rises.
        op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        check("flush pre busy", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush busy",   32'(busy_o), 32'd0);
        check("flush done",   32'(done_o), 32'd0);
        check("flush result", result_o,    last_exp);
        seen_done = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o) seen_done++;
        end
        check("flush no done", 32'(seen_done), 32'd0);
        do_op(OP_DIVU, 32'd9, 32'd3, 1'b0, "divu 9/3");          release_done("divu 9/3");

        // Back-to-back: start without ack is ignored; start with ack launches immediately.
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "b2b first");
        op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("ignored start done",   32'(done_o), 32'd1);
        check("ignored start busy",   32'(busy_o), 32'd0);
        check("ignored start result", result_o,    32'd14);
        do_op(OP_DIVU, 32'd50, 32'd5, 1'b1, "b2b divu 50/5");    release_done("b2b divu 50/5");

        // Random sweep mixing special cases, small dividends and full-width operands.
        for (int n = 0; n < 48; n++) begin
            rop  = 2'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 5));
            ra   = $urandom;
            rb   = $urandom;
            case (kind)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                3: rb = $urandom_range(1, 15);
                4: rb = -rb >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(rop, ra, rb, 1'b0, "random");
            release_done("random");
        end

        // Asynchronous reset mid-operation clears outputs before the next edge.
        op_i = OP_DIV; dividend_i = 32'd12345; divisor_i = 32'd17; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #3 reset_i = 1'b1;
        #1;
        check("async reset busy",   32'(busy_o), 32'd0);
        check("async reset done",   32'(done_o), 32'd0);
        check("async reset result", result_o,    32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        do_op(OP_REM, 32'hFFFF_CFC7, 32'd17, 1'b0, "post reset rem");
        release_done("post reset rem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_divider.md
# multicycle_divider

Parametrised iterative integer divider for the execute stage, replacing the inline fixed-32-bit shift-subtract divider. Executes RV32M DIV/DIVU/REM/REMU, or the equivalent ops at any XLEN, using a start/busy/done/ack handshake. Division-by-zero and signed overflow follow the RISC-V rules. Supports pipeline flush mid-operation and, as a build option, early termination on small dividends.

## Interface
- XLEN, 32: operand and result width; must be ≥ 8 and a power of two.
- clk_i  input  1  clock.
- reset_i  input  1  reset; one clock; reset is asynchronous and active-high.
- start_i  input  1  request a new division; accepted only in IDLE, or in DONE together with ack_i.
- op_i  input  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  input  XLEN  rs1 value; sampled on an accepted start.
- divisor_i  input  XLEN  rs2 value; sampled on an accepted start.
- flush_i  input  1  abort any operation and return to IDLE.
- ack_i  input  1  consumer has taken result_o; releases DONE.
- busy_o  output  1  high in CALC and FIXUP.
- done_o  output  1  high in DONE; result_o is valid.
- result_o  output  XLEN  quotient or remainder; held stable in DONE.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- **IDLE, on start_i:**
  - Latch op, sign flags and the absolute values |a| and |b|. Absolute values are taken only for signed ops; |−2^(XLEN−1)| = 2^(XLEN−1) as unsigned XLEN.
  - Divisor zero: result = all ones (DIV/DIVU) or the dividend (REM/REMU). Go directly to DONE.
  - Signed overflow (dividend −2^(XLEN−1), divisor all ones, op DIV/REM): result = −2^(XLEN−1) (DIV) or 0 (REM). Go directly to DONE.
  - Otherwise go to CALC with the bit counter = XLEN−1.
- **CALC:** restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is XLEN+1 bits: r' = {r, a[k]}.
  - If r' ≥ |b|, then r = r' − |b| and q[k] = 1.
  - Counter decrements each cycle. After the counter-0 step, go to FIXUP.
- **FIXUP:**
  - Quotient negated if op is DIV and the operand signs differ.
  - Remainder negated if op is REM and the dividend is negative.
  - Select quotient or remainder into result_o, then go to DONE.
- **DONE:**
  - Hold result_o and done_o.
  - ack_i alone → IDLE.
  - ack_i with start_i → accept the new op; same behaviour as IDLE on start.
- start_i while busy, or in DONE without ack_i, is ignored (no queueing).
- flush_i in any state → IDLE on the next edge; busy_o and done_o low. result_o is unchanged. flush_i beats start_i and ack_i in the same cycle.
- reset_i mid-operation → IDLE immediately (asynchronous); all state cleared.

## Timing
- Reset values: busy_o 0, done_o 0, result_o 0, state IDLE, counter 0.
- Special cases (zero divisor, overflow): done_o high 1 cycle after the start edge.
- Normal case without early-out: busy_o high for XLEN+1 cycles (XLEN CALC, 1 FIXUP). done_o rises XLEN+2 cycles after the start edge, i.e. 34 cycles at XLEN=32.
- Back-to-back: the start+ack cycle in DONE loses no cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **DIV_EARLY_OUT_EN defined:**
  - In IDLE, the counter is initialised to XLEN−1−lz, where lz = leading zeros of |a|. Quotient bits above that position are provably zero.
  - |a| = 0 takes the special-case path: quotient 0, remainder 0, DONE in 1 cycle.
  - Latency becomes (XLEN−lz)+2 cycles.
- **DIV_EARLY_OUT_EN undefined:** the counter always starts at XLEN−1. No leading-zero logic is instantiated; latency is fixed as stated in Timing.
- Results must be bit-identical with and without the macro.

## Structure
- Shared package: op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU), the state enum, and the counter width $clog2(XLEN).
- One sub-module, present only under DIV_EARLY_OUT_EN: leading_zero_count. It is parametrised by XLEN and is purely combinational.

## Test plan
- DIVU 100 / 7, XLEN=32, macro off → done_o at cycle 34, result 14. Then REMU on the same operands → 2.
- DIV −7 / 2 → −3 (0xFFFFFFFD). REM −7 / 2 → −1. REM 7 / −2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on that pair → 0. Each has done_o 1 cycle after start.
- Flush: start DIVU 1000 / 3, assert flush_i at CALC cycle 10 → IDLE next cycle, done_o never rises. A following DIVU 9 / 3 → 3.
- Back-to-back: in DONE, assert ack_i+start_i with DIVU 50 / 5 → the new op starts with no gap, result 10. start_i without ack_i in DONE is ignored and result_o holds.
- Macro on: DIVU 3 / 1 → done_o 4 cycles after start, result 3. DIVU 0 / 9 → 1 cycle, result 0. A random sweep matches the macro-off results.
